// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the data-memory master FSM state type.
package axi_pkg;

  localparam int unsigned AXI_LEN_W  = 8;
  localparam int unsigned AXI_SIZE_W = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_RESP_W = 2;
  localparam int unsigned AXI_STRB_W = 4;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_WORD  = 3'b010;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0]  AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB,
    StDone
  } dm_state_e;

endpackage

// File: rtl/dm_axi_master.sv
// CPU data-memory port to AXI4 master bridge: one single-beat AXI transaction per
// load/store, with cpu_stall holding the pipeline until the transaction completes.
module dm_axi_master
  import axi_pkg::*;
#(
  parameter int unsigned       ID_W   = 4,
  parameter logic [ID_W-1:0]   MST_ID = 4'h1,
  parameter int unsigned       ADDR_W = 32,
  parameter int unsigned       DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_rd,
  input  logic                   cpu_wr,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [DATA_W-1:0]      cpu_wdata,
  input  logic [AXI_STRB_W-1:0]  cpu_bweb,
  output logic [DATA_W-1:0]      cpu_rdata,
  output logic                   cpu_stall,
  output logic                   bus_err,
  output logic [ID_W-1:0]        arid,
  output logic [ADDR_W-1:0]      araddr,
  output logic [AXI_LEN_W-1:0]   arlen,
  output logic [AXI_SIZE_W-1:0]  arsize,
  output logic [AXI_BURST_W-1:0] arburst,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [ID_W-1:0]        rid,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [AXI_RESP_W-1:0]  rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [ID_W-1:0]        awid,
  output logic [ADDR_W-1:0]      awaddr,
  output logic [AXI_LEN_W-1:0]   awlen,
  output logic [AXI_SIZE_W-1:0]  awsize,
  output logic [AXI_BURST_W-1:0] awburst,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_W-1:0]      wdata,
  output logic [AXI_STRB_W-1:0]  wstrb,
  output logic                   wlast,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [ID_W-1:0]        bid,
  input  logic [AXI_RESP_W-1:0]  bresp,
  input  logic                   bvalid,
  output logic                   bready
);

  dm_state_e             state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [AXI_STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  aw_ok_q, aw_ok_d;
  logic                  w_ok_q, w_ok_d;
  logic                  bus_err_q, bus_err_d;

  // Single outstanding transaction, so response IDs and rlast carry no information.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{rid, bid, rlast};

  assign arid    = MST_ID;
  assign awid    = MST_ID;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arlen   = '0;
  assign awlen   = '0;
  assign arsize  = AXI_SIZE_WORD;
  assign awsize  = AXI_SIZE_WORD;
  assign arburst = AXI_BURST_INCR;
  assign awburst = AXI_BURST_INCR;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;

  assign cpu_rdata = rdata_q;
  assign bus_err   = bus_err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    aw_ok_d   = aw_ok_q;
    w_ok_d    = w_ok_q;
    bus_err_d = 1'b0;
    cpu_stall = 1'b1;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        cpu_stall = cpu_rd | cpu_wr;
        aw_ok_d   = 1'b0;
        w_ok_d    = 1'b0;
        if (cpu_rd || cpu_wr) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          wstrb_d = ~cpu_bweb;
          // A simultaneous load and store request issues the store.
          state_d = cpu_wr ? StWrAw : StRdA;
        end
      end
      StRdA: begin
        arvalid = 1'b1;
        if (arready) state_d = StRdD;
      end
      StRdD: begin
        rready = 1'b1;
        if (rvalid) begin
          rdata_d   = rdata;
          bus_err_d = (rresp != AXI_RESP_OKAY);
          state_d   = StDone;
        end
      end
      StWrAw: begin
        awvalid = ~aw_ok_q;
        wvalid  = ~w_ok_q;
        if (!aw_ok_q && awready) aw_ok_d = 1'b1;
        if (!w_ok_q && wready) w_ok_d = 1'b1;
        if (aw_ok_d && w_ok_d) state_d = StWrB;
      end
      StWrB: begin
        bready = 1'b1;
        if (bvalid) begin
          bus_err_d = (bresp != AXI_RESP_OKAY);
          state_d   = StDone;
        end
      end
      StDone: begin
        // Release cycle: CPU advances; a new request is only sampled back in idle.
        cpu_stall = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      aw_ok_q   <= aw_ok_d;
      w_ok_q    <= w_ok_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: scripted AXI slave, transaction-level reference
// model checked every cycle, plus literal expectations per scenario.
module tb_dm_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_bweb;
  logic        cpu_stall, bus_err;
  logic [3:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  dm_axi_master dut (
    .clk(clk), .rst(rst),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_bweb(cpu_bweb), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .bus_err(bus_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] sl_rdata = '0;
  logic [1:0]  sl_rresp = '0, sl_bresp = '0;
  bit          noise = 0;

  logic [31:0] cap_araddr = '0, cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, ar_hs_cnt = 0, arvalid_cycles = 0;
  int          err_cycles = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scripted slave: each ready rises after its programmed wait, responses follow handshakes.
  initial begin
    int  ar_w, aw_w, w_w, r_w, b_w;
    bit  rd_pend, awg, wg, b_pend;
    bit  h_ar, h_r, h_aw, h_w, h_b, rs;
    ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
    rd_pend = 0; awg = 0; wg = 0; b_pend = 0;
    arready = 0; rvalid = 0; rdata = '0; rresp = '0; rlast = 1'b1; rid = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = '0; bid = '0;
    forever begin
      @(negedge clk);
      h_ar = arvalid && arready;
      h_r  = rvalid && rready;
      h_aw = awvalid && awready;
      h_w  = wvalid && wready;
      h_b  = bvalid && bready;
      rs   = rst;
      if (!rs) begin
        if (h_ar) begin cap_araddr = araddr; ar_hs_cnt++; end
        if (h_aw) begin cap_awaddr = awaddr; aw_hs_cnt++; end
        if (h_w) begin cap_wdata = wdata; cap_wstrb = wstrb; w_hs_cnt++; end
        if (arvalid) arvalid_cycles++;
      end
      @(posedge clk);
      #1;
      if (rs) begin
        rd_pend = 0; awg = 0; wg = 0; b_pend = 0;
        ar_w = 0; aw_w = 0; w_w = 0; r_w = 0; b_w = 0;
        arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
        continue;
      end
      if (h_r) begin rvalid = 0; rd_pend = 0; end
      if (h_ar) begin rd_pend = 1; r_w = 0; end
      if (h_b) begin bvalid = 0; b_pend = 0; awg = 0; wg = 0; end
      if (h_aw) awg = 1;
      if (h_w) wg = 1;
      if (awg && wg && !b_pend) begin b_pend = 1; b_w = 0; end
      if (rd_pend && !rvalid) begin
        if (r_w >= r_dly) begin rvalid = 1; rdata = sl_rdata; rresp = sl_rresp; end
        else r_w++;
      end
      if (b_pend && !bvalid) begin
        if (b_w >= b_dly) begin bvalid = 1; bresp = sl_bresp; end
        else b_w++;
      end
      if (!arvalid) ar_w = 0;
      arready = arvalid && (ar_w >= ar_dly);
      if (arvalid && !arready) ar_w++;
      if (!awvalid) aw_w = 0;
      awready = awvalid && (aw_w >= aw_dly);
      if (awvalid && !awready) aw_w++;
      if (!wvalid) w_w = 0;
      wready = wvalid && (w_w >= w_dly);
      if (wvalid && !wready) w_w++;
      if (noise) begin
        rid = 4'($urandom);
        bid = 4'($urandom);
        if (!rvalid) begin rdata = $urandom; rresp = 2'($urandom); end
        if (!bvalid) bresp = 2'($urandom);
        if (!awvalid) awready = 1'($urandom);
        if (!wvalid) wready = 1'($urandom);
      end
    end
  end

  // Reference model: one outstanding request, a release cycle after each response.
  initial begin
    bit          busy, op_wr, ar_d, aw_d, w_d, rel, rel_n, exp_err;
    bit          e_ar, e_r, e_aw, e_w, e_b;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_strb;
    busy = 0; op_wr = 0; ar_d = 0; aw_d = 0; w_d = 0; rel = 0; exp_err = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_strb = '0;
    wait (chk_en);
    forever begin
      @(negedge clk);
      e_ar = busy && !op_wr && !ar_d;
      e_r  = busy && !op_wr && ar_d;
      e_aw = busy && op_wr && !aw_d;
      e_w  = busy && op_wr && !w_d;
      e_b  = busy && op_wr && aw_d && w_d;
      chk("cpu_stall", cpu_stall, rel ? 1'b0 : busy ? 1'b1 : (cpu_rd | cpu_wr));
      chk("bus_err", bus_err, rel ? exp_err : 1'b0);
      chk("cpu_rdata", cpu_rdata, m_rdata);
      chk("arvalid", arvalid, e_ar);
      chk("rready", rready, e_r);
      chk("awvalid", awvalid, e_aw);
      chk("wvalid", wvalid, e_w);
      chk("bready", bready, e_b);
      if (arvalid) begin
        chk("araddr", araddr, m_addr);
        chk("ar_fields", {arid, arlen, arsize, arburst}, {4'h1, 8'd0, 3'b010, 2'b01});
      end
      if (awvalid) begin
        chk("awaddr", awaddr, m_addr);
        chk("aw_fields", {awid, awlen, awsize, awburst}, {4'h1, 8'd0, 3'b010, 2'b01});
      end
      if (wvalid) begin
        chk("wdata", wdata, m_wdata);
        chk("wstrb_wlast", {wstrb, wlast}, {m_strb, 1'b1});
      end
      if (bus_err) err_cycles++;
      rel_n = 0;
      if (busy) begin
        if (e_ar && arready) ar_d = 1;
        if (e_r && rvalid) begin
          rel_n = 1; busy = 0; m_rdata = rdata; exp_err = (rresp != 2'b00);
        end
        if (e_aw && awready) aw_d = 1;
        if (e_w && wready) w_d = 1;
        if (e_b && bvalid) begin
          rel_n = 1; busy = 0; exp_err = (bresp != 2'b00);
        end
      end else if (!rel && (cpu_rd || cpu_wr)) begin
        busy = 1; op_wr = cpu_wr; m_addr = cpu_addr; m_wdata = cpu_wdata;
        m_strb = ~cpu_bweb; ar_d = 0; aw_d = 0; w_d = 0;
      end
      rel = rel_n;
      if (rst) begin
        busy = 0; rel = 0; m_rdata = '0; exp_err = 0;
      end
    end
  end

  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] bw,
                         output int n, output logic err, output logic [31:0] rdv);
    @(posedge clk);
    #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; cpu_bweb = bw;
    n = 0;
    forever begin
      @(negedge clk);
      if (!cpu_stall) break;
      n++;
      if (n > 100) begin
        n_chk++; n_fail++;
        $display("FAIL txn_timeout: still stalled after %0d cycles, required release", n);
        break;
      end
    end
    err = bus_err;
    rdv = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_rd = 0; cpu_wr = 0;
  endtask

  initial begin
    int          n, k, av0, aw0, w0, e0;
    logic        err;
    logic [31:0] rdv;
    rst = 1; cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_bweb = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("rst_readies", {rready, bready}, 2'b00);
    @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;

    // Zero-wait load
    sl_rdata = 32'hDEADBEEF;
    run_txn(1, 0, 32'h0000_0040, 32'h0, 4'hF, n, err, rdv);
    chk("t1_stall_cycles", n, 3);
    chk("t1_rdata", rdv, 32'hDEADBEEF);
    chk("t1_err", err, 1'b0);
    chk("t1_araddr", cap_araddr, 32'h0000_0040);

    // Zero-wait store with partial byte enables
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    run_txn(0, 1, 32'h0000_0100, 32'h1234_5678, 4'b1100, n, err, rdv);
    chk("t2_stall_cycles", n, 3);
    chk("t2_wstrb", cap_wstrb, 4'b0011);
    chk("t2_awaddr", cap_awaddr, 32'h0000_0100);
    chk("t2_wdata", cap_wdata, 32'h1234_5678);
    chk("t2_rdata_kept", rdv, 32'hDEADBEEF);
    chk("t2_hs", {aw_hs_cnt - aw0, w_hs_cnt - w0}, {32'd1, 32'd1} >> 0 == 0 ? 0 : 1);

    // Address accepted before data, then data before address
    for (int i = 0; i < 2; i++) begin
      aw_dly = (i == 0) ? 0 : 3;
      w_dly  = (i == 0) ? 3 : 0;
      aw0 = aw_hs_cnt; w0 = w_hs_cnt;
      run_txn(0, 1, 32'h0000_0200 + i, 32'hA0A0_0000 + i, 4'b0000, n, err, rdv);
      chk("t3_stall_cycles", n, 6);
      chk("t3_aw_hs", aw_hs_cnt - aw0, 1);
      chk("t3_w_hs", w_hs_cnt - w0, 1);
    end
    aw_dly = 0; w_dly = 0;

    // Slow arready under noisy unrelated inputs
    ar_dly = 5; noise = 1; sl_rdata = 32'h0BAD_F00D;
    av0 = arvalid_cycles;
    run_txn(1, 0, 32'h2000_0004, 32'h0, 4'hF, n, err, rdv);
    chk("t4_stall_cycles", n, 8);
    chk("t4_arvalid_cycles", arvalid_cycles - av0, 6);
    chk("t4_rdata", rdv, 32'h0BAD_F00D);
    ar_dly = 0; noise = 0;

    // SLVERR on a store: single-cycle error pulse
    sl_bresp = 2'b10;
    e0 = err_cycles;
    run_txn(0, 1, 32'h0000_0300, 32'h0, 4'hF, n, err, rdv);
    repeat (3) @(negedge clk);
    chk("t5_err", err, 1'b1);
    chk("t5_err_pulse_cycles", err_cycles - e0, 1);
    chk("t5_stall_cycles", n, 3);
    sl_bresp = 2'b00;

    // DECERR on a load: data still forwarded
    sl_rresp = 2'b11; sl_rdata = 32'hCAFE_F00D;
    run_txn(1, 0, 32'h0000_0044, 32'h0, 4'hF, n, err, rdv);
    chk("t5b_err", err, 1'b1);
    chk("t5b_rdata", rdv, 32'hCAFE_F00D);
    sl_rresp = 2'b00;

    // Reset while waiting for read data, then simultaneous rd/wr
    r_dly = 3;
    @(posedge clk);
    #1;
    cpu_rd = 1; cpu_addr = 32'h0000_0080;
    k = 0;
    forever begin
      @(negedge clk);
      if (rready) break;
      k++;
      if (k > 50) begin
        n_chk++; n_fail++;
        $display("FAIL t6_rready_timeout: rready never seen, required 1");
        break;
      end
    end
    @(posedge clk);
    #1;
    rst = 1; cpu_rd = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("t6_valids", {arvalid, awvalid, wvalid}, 3'b000);
    chk("t6_readies", {rready, bready}, 2'b00);
    chk("t6_stall", cpu_stall, 1'b0);
    r_dly = 0;
    av0 = arvalid_cycles; aw0 = aw_hs_cnt;
    run_txn(1, 1, 32'h0000_0300, 32'h55AA_55AA, 4'h0, n, err, rdv);
    chk("t6_stall_cycles", n, 3);
    chk("t6_no_ar", arvalid_cycles - av0, 0);
    chk("t6_aw_hs", aw_hs_cnt - aw0, 1);
    chk("t6_awaddr", cap_awaddr, 32'h0000_0300);
    chk("t6_rdata_cleared", rdv, 32'h0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
